// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM states, mode bit positions, mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Bit positions inside the 2-bit mode word {CPOL,CPHA}
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK edge generator: one-cycle strobe every CLK_DIV cycles while enabled,
// plus a flag telling whether the upcoming edge is the leading (odd) one.
module spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic edge_o,
  output logic lead_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          phase_q, phase_d;

  // Divider count and edge parity; both clear whenever disabled
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en_i) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + CW'(1);
    end
  end

  // Divider state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign edge_o = en_i && (div_q == DIV_LAST);
  assign lead_o = ~phase_q;

endmodule

// File: rtl/spi_master_n.sv
// Parametrised SPI master: per-transfer mode/order/slave capture, start/busy/done
// handshake, shared SCLK/MOSI/MISO bus with one active-low select per slave.
module spi_master_n
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 3,
  parameter int CLK_DIV = 2,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [SS_W-1:0]   slaveselct_i,
  input  logic [1:0]        mode_i,
  input  logic              lsb_first_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_n_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]    TMR_LAST = CW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxout_q, rxout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     tmr_q, tmr_d;
  logic [1:0]        mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [SS_W-1:0]   idx_q, idx_d;
  logic              sclk_q, sclk_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic sck_edge, sck_lead, ss_ok, smp;

  assign ss_ok = (int'(slaveselct_i) < NUM_SS);

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i  (clk_i),
    .rst_ni (reset_ni),
    .en_i   (state_q == ST_XFER),
    .edge_o (sck_edge),
    .lead_o (sck_lead)
  );

  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
  assign smp = sck_lead ^ mode_q[CPHA_BIT];

  // Next-state logic: capture on start, shift/sample on SCLK edges, timed SETUP/HOLD
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxout_d = rxout_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    mode_d  = mode_q;
    lsb_d   = lsb_q;
    idx_d   = idx_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = mode_i[CPOL_BIT];
        if (start_i) begin
          if (ss_ok) begin
            tx_d    = tx_data_i;
            rx_d    = '0;
            mode_d  = mode_i;
            lsb_d   = lsb_first_i;
            idx_d   = slaveselct_i;
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ST_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          state_d = ST_XFER;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end
      ST_XFER: begin
        if (sck_edge) begin
          sclk_d = ~sclk_q;
          if (smp) begin
            rx_d  = lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
            cnt_d = cnt_q + CNT_W'(1);
          end else if (!mode_q[CPHA_BIT] || (cnt_q != '0)) begin
            // With CPHA=1 the first odd edge re-drives bit 0 instead of shifting
            tx_d = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
          end
          // Last edge is a trailing one after all samples are in
          if (!sck_lead && (cnt_d == CNT_FULL)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          rxout_d = rx_q;
          done_d  = 1'b1;
          sclk_d  = mode_q[CPOL_BIT];
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end
    endcase
  end

  // State registers; reset drops the transfer and returns everything to idle
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rxout_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= MODE0;
      lsb_q   <= 1'b0;
      idx_q   <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxout_q <= rxout_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      mode_q  <= mode_d;
      lsb_q   <= lsb_d;
      idx_q   <= idx_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Select decode: only the captured slave is driven low while a transfer is active
  always_comb begin
    ss_n_o = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if ((state_q != ST_IDLE) && (idx_q == SS_W'(i))) ss_n_o[i] = 1'b0;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign mosi_o    = (state_q == ST_IDLE) ? 1'b0 : (lsb_q ? tx_q[0] : tx_q[DATA_W-1]);
  assign sclk_o    = sclk_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rx_data_o = rxout_q;

endmodule

// File: tb/tb_spi_master_n.sv
// Bench for spi_master_n: table vectors, random transfers against a behavioural
// slave, invalid-select, mid-transfer reset and a wide back-to-back configuration.
module tb_spi_master_n;

  localparam int DW  = 8,  NS  = 3, CD  = 2;
  localparam int DW2 = 16, NS2 = 4, CD2 = 3;
  localparam int LAT  = 1 + CD  * (2 * DW  + 2);
  localparam int LAT2 = 1 + CD2 * (2 * DW2 + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // DUT 1 (defaults)
  logic          start = 1'b0;
  logic [1:0]    ssel = '0;
  logic [1:0]    mode = '0;
  logic          lsb = 1'b0;
  logic [DW-1:0] tx = '0;
  logic [DW-1:0] rx;
  logic          busy, done, err, sclk, mosi, miso;
  logic [NS-1:0] ss_n;

  // DUT 2 (wide, four slaves, slower SCLK) in loopback
  logic           start2 = 1'b0;
  logic [1:0]     ssel2 = '0;
  logic [1:0]     mode2 = '0;
  logic           lsb2 = 1'b0;
  logic [DW2-1:0] tx2 = '0;
  logic [DW2-1:0] rx2;
  logic           busy2, done2, err2, sclk2, mosi2;
  logic [NS2-1:0] ss_n2;

  spi_master_n u_dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .slaveselct_i(ssel),
    .mode_i(mode), .lsb_first_i(lsb), .tx_data_i(tx), .rx_data_o(rx),
    .busy_o(busy), .done_o(done), .err_o(err), .sclk_o(sclk), .mosi_o(mosi),
    .miso_i(miso), .ss_n_o(ss_n)
  );

  spi_master_n #(.DATA_W(DW2), .NUM_SS(NS2), .CLK_DIV(CD2)) u_dut2 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start2), .slaveselct_i(ssel2),
    .mode_i(mode2), .lsb_first_i(lsb2), .tx_data_i(tx2), .rx_data_o(rx2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .sclk_o(sclk2), .mosi_o(mosi2),
    .miso_i(mosi2), .ss_n_o(ss_n2)
  );

  // Behavioural slave: drives its word in transfer order, records what it samples
  logic          loop_en = 1'b0;
  logic          sl_miso = 1'b0;
  logic [1:0]    sl_mode = '0;
  logic          sl_lsb = 1'b0;
  logic [DW-1:0] sl_word = '0;
  logic [NS-1:0] exp_ss = '1;
  logic          sl_act = 1'b0;
  logic          sl_prev = 1'b0;
  int            sl_edges = 0, sl_lead = 0, sl_trail = 0, sl_ns = 0;
  logic          sl_bits [DW];
  int            ss_bad = 0, err_cnt = 0, done_cnt = 0;

  assign miso = loop_en ? mosi : sl_miso;

  function automatic logic seq_bit(input logic [DW-1:0] w, input logic l, input int k);
    return l ? w[k] : w[DW-1-k];
  endfunction

  always @(negedge clk) begin
    if (ss_n !== '1 && !sl_act) begin
      sl_act   <= 1'b1;
      sl_edges <= 0;
      sl_lead  <= 0;
      sl_trail <= 0;
      sl_ns    <= 0;
      sl_miso  <= seq_bit(sl_word, sl_lsb, 0);
    end else if (ss_n === '1) begin
      sl_act <= 1'b0;
    end else if (sclk !== sl_prev) begin
      sl_edges <= sl_edges + 1;
      if (sclk !== sl_mode[1]) begin
        // leading edge
        if (!sl_mode[0]) begin
          if (sl_ns < DW) sl_bits[sl_ns] <= mosi;
          sl_ns <= sl_ns + 1;
        end else if (sl_lead < DW) begin
          sl_miso <= seq_bit(sl_word, sl_lsb, sl_lead);
        end
        sl_lead <= sl_lead + 1;
      end else begin
        // trailing edge
        if (sl_mode[0]) begin
          if (sl_ns < DW) sl_bits[sl_ns] <= mosi;
          sl_ns <= sl_ns + 1;
        end else if (sl_trail + 1 < DW) begin
          sl_miso <= seq_bit(sl_word, sl_lsb, sl_trail + 1);
        end
        sl_trail <= sl_trail + 1;
      end
    end
    sl_prev <= sclk;
    if (busy && ss_n !== exp_ss) ss_bad <= ss_bad + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: no done within cycle budget", nm);
  endtask

  // One transfer on DUT 1 with full protocol checking
  task automatic do_xfer(input string nm, input logic [1:0] m, input logic l,
                         input logic [1:0] idx, input logic [DW-1:0] t_w,
                         input logic [DW-1:0] s_w, input logic lp,
                         input logic [DW-1:0] exp_rx);
    int t0, bad0, err0;
    bit seen;
    logic [DW-1:0] got;
    @(negedge clk);
    mode = m; lsb = l; ssel = idx; tx = t_w; loop_en = lp;
    sl_mode = m; sl_lsb = l; sl_word = s_w;
    exp_ss = ~(NS'(1) << idx);
    @(negedge clk);
    chk({nm, " sclk idle before"}, 32'(sclk), 32'(m[1]));
    bad0 = ss_bad; err0 = err_cnt;
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy at t+1"}, 32'(busy), 32'd1);
    chk({nm, " ss_n at t+1"}, 32'(ss_n), 32'(exp_ss));
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    if (!seen) begin
      timeout(nm);
      return;
    end
    chk({nm, " done latency"}, 32'(cyc - t0), 32'(LAT));
    chk({nm, " rx_data"}, 32'(rx), 32'(exp_rx));
    chk({nm, " busy at done"}, 32'(busy), 32'd0);
    chk({nm, " ss_n at done"}, 32'(ss_n), 32'(NS'('1)));
    chk({nm, " sclk idle after"}, 32'(sclk), 32'(m[1]));
    chk({nm, " sclk edges"}, 32'(sl_edges), 32'(2 * DW));
    chk({nm, " samples"}, 32'(sl_ns), 32'(DW));
    for (int k = 0; k < DW; k++) got[l ? k : DW - 1 - k] = sl_bits[k];
    chk({nm, " mosi stream"}, 32'(got), 32'(t_w));
    chk({nm, " ss_n during busy"}, 32'(ss_bad - bad0), 32'd0);
    chk({nm, " no err"}, 32'(err_cnt - err0), 32'd0);
  endtask

  task automatic wait_done2(output bit ok);
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = (done2 === 1'b1);
    end
  endtask

  typedef struct {
    logic [1:0]    m;
    logic          l;
    logic [1:0]    idx;
    logic [DW-1:0] txw;
    logic [DW-1:0] sw;
    logic          lp;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t vt [6];

  initial begin
    int t0, d0, e0;
    logic [DW-1:0] r0, rt, rs;
    logic [1:0] rm;
    logic rl, rlp;
    bit ok;

    vt[0] = '{2'd0, 1'b0, 2'd1, 8'h55, 8'hAA, 1'b0, 8'hAA};
    vt[1] = '{2'd0, 1'b0, 2'd0, 8'hC3, 8'h00, 1'b1, 8'hC3};
    vt[2] = '{2'd1, 1'b0, 2'd2, 8'hC3, 8'h00, 1'b1, 8'hC3};
    vt[3] = '{2'd2, 1'b0, 2'd1, 8'hC3, 8'h00, 1'b1, 8'hC3};
    vt[4] = '{2'd3, 1'b0, 2'd0, 8'hC3, 8'h00, 1'b1, 8'hC3};
    vt[5] = '{2'd0, 1'b1, 2'd2, 8'h01, 8'h01, 1'b0, 8'h01};

    // Reset state
    #12;
    chk("reset sclk", 32'(sclk), 32'd0);
    chk("reset mosi", 32'(mosi), 32'd0);
    chk("reset ss_n", 32'(ss_n), 32'(NS'('1)));
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rx", 32'(rx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_xfer($sformatf("vec%0d", i), vt[i].m, vt[i].l, vt[i].idx, vt[i].txw,
              vt[i].sw, vt[i].lp, vt[i].exp_rx);

    // Invalid slave index
    @(negedge clk);
    r0 = rx; e0 = err_cnt;
    ssel = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("badsel err pulse", 32'(err), 32'd1);
    chk("badsel busy", 32'(busy), 32'd0);
    chk("badsel ss_n", 32'(ss_n), 32'(NS'('1)));
    @(negedge clk);
    chk("badsel err single", 32'(err), 32'd0);
    @(negedge clk);
    chk("badsel err count", 32'(err_cnt - e0), 32'd1);
    chk("badsel rx held", 32'(rx), 32'(r0));
    chk("badsel still idle", 32'(busy), 32'd0);

    // Random transfers; expected rx is the slave word, or tx in loopback
    for (int i = 0; i < 16; i++) begin
      rm  = 2'($urandom_range(0, 3));
      rl  = 1'($urandom_range(0, 1));
      rlp = 1'($urandom_range(0, 1));
      rt  = DW'($urandom);
      rs  = DW'($urandom);
      do_xfer($sformatf("rand%0d", i), rm, rl, 2'($urandom_range(0, NS - 1)),
              rt, rs, rlp, rlp ? rt : rs);
    end

    // Reset in the middle of a transfer
    @(negedge clk);
    mode = 2'd2; lsb = 1'b0; ssel = 2'd0; tx = 8'h96; loop_en = 1'b1;
    sl_mode = 2'd2; sl_lsb = 1'b0; exp_ss = ~(NS'(1));
    @(negedge clk);
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset ss_n", 32'(ss_n), 32'(NS'('1)));
    chk("midreset sclk", 32'(sclk), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset mosi", 32'(mosi), 32'd0);
    chk("midreset rx", 32'(rx), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset no done", 32'(done_cnt - d0), 32'd0);
    do_xfer("after reset", 2'd1, 1'b0, 2'd2, 8'h3C, 8'hE7, 1'b0, 8'hE7);

    // Wide configuration, back-to-back transfers
    @(negedge clk);
    mode2 = 2'd1; lsb2 = 1'b0; ssel2 = 2'd3; tx2 = 16'hA5C3;
    @(negedge clk);
    start2 = 1'b1; t0 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    chk("w16 busy", 32'(busy2), 32'd1);
    chk("w16 ss_n", 32'(ss_n2), 32'h7);
    wait_done2(ok);
    if (!ok) timeout("w16 first");
    else begin
      chk("w16 latency1", 32'(cyc - t0), 32'(LAT2));
      chk("w16 rx1", 32'(rx2), 32'hA5C3);
      chk("w16 sclk idle", 32'(sclk2), 32'd0);
      // start in the done cycle
      mode2 = 2'd2; lsb2 = 1'b1; ssel2 = 2'd0; tx2 = 16'h1E2D;
      start2 = 1'b1; t0 = cyc;
      @(negedge clk);
      start2 = 1'b0;
      chk("w16 no idle gap", 32'(busy2), 32'd1);
      chk("w16 ss_n2", 32'(ss_n2), 32'hE);
      wait_done2(ok);
      if (!ok) timeout("w16 second");
      else begin
        chk("w16 latency2", 32'(cyc - t0), 32'(LAT2));
        chk("w16 rx2", 32'(rx2), 32'h1E2D);
        chk("w16 sclk idle2", 32'(sclk2), 32'd1);
        chk("w16 err", 32'(err2), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_n.md
# spi_master_n

Parametrised SPI master, the next generation of the team's fixed 8-bit, three-slave master. It adds configurable word width, slave count and SCLK divider, all four SPI modes captured per transfer, MSB/LSB-first ordering, and a start/busy/done handshake toward the host logic. It sits between the host datapath and the shared SCLK/MOSI/MISO bus with one active-low select per slave.

## Interface
- DATA_W, 8: bits per transfer, ≥2
- NUM_SS, 3: number of slave selects, ≥1
- CLK_DIV, 2: clk cycles per SCLK half-period, ≥1
- SS_W, $clog2(NUM_SS) (min 1): width of slaveselct
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only while busy=0
- slaveselct  in  SS_W  target slave index, captured at start
- mode  in  2  {CPOL,CPHA}, captured at start
- lsb_first  in  1  1: LSB shifted first; captured at start
- tx_data  in  DATA_W  word to send, captured at start
- rx_data  out  DATA_W  received word, valid from done, held until next done
- busy  out  1  high from the cycle after acceptance through the HOLD state
- done  out  1  one-cycle pulse at transfer end
- err  out  1  one-cycle pulse when start carries slaveselct ≥ NUM_SS
- sclk  out  1  serial clock
- mosi  out  1  serial data out
- miso  in  1  serial data in; the bus is shared by all slaves
- ss_n  out  NUM_SS  active-low selects; at most one is low

## Operation
- States: IDLE, SETUP, XFER, HOLD. A valid start in IDLE loads the shift register and the captured mode, order and index, then enters SETUP.
- An invalid index asserts err for one cycle. The block stays in IDLE, busy stays 0, and rx_data is unchanged.
- SETUP: the selected ss_n goes low and mosi presents the first bit. Lasts CLK_DIV cycles, then XFER.
- XFER: 2·DATA_W SCLK edges, one every CLK_DIV cycles. sclk toggles from CPOL at each edge.
  - CPHA=0: sample miso on odd edges (1,3,…), shift mosi on even edges.
  - CPHA=1: shift mosi on odd edges, sample on even edges. The first bit is therefore also driven on edge 1.
- A bit counter of width $clog2(DATA_W)+1 counts samples. XFER exits after edge 2·DATA_W, and sclk is then back at CPOL.
- HOLD: ss_n stays low for CLK_DIV cycles. At exit, ss_n goes all-high, rx_data is updated, done pulses, and the state returns to IDLE.
- Received bits fill in the same order as transmit: with lsb_first=0 the first sampled bit becomes rx_data[DATA_W-1].
- In IDLE, sclk follows the live mode[1]. mosi is 0 in IDLE.
- Input changes during busy are ignored. start while busy is ignored, with no err.

## Timing
- Reset values: sclk=0, mosi=0, ss_n=all 1, busy=0, done=0, err=0, rx_data=0, state=IDLE. The captured mode resets to 0.
- Reset asserted mid-transfer: all outputs take their reset values immediately and asynchronously. No done is issued. The partial word is discarded.
- start sampled high in cycle t: ss_n low and busy high from t+1.
- done is high in cycle t+1+CLK_DIV·(2·DATA_W+2). With the defaults this is t+37.
- ss_n returns high and busy drops in the same cycle as done. rx_data is valid in that cycle.
- Back-to-back transfers: start may be high in the done cycle and is accepted. The next SETUP begins in the following cycle.
- CLK_DIV=1: SCLK runs at clk/2 and the edge strobe fires every cycle in XFER.

## Structure
- Shared package spi_pkg holds:
  - the state enum;
  - CPOL/CPHA bit-index constants;
  - mode constants MODE0–MODE3.
- One sub-module, spi_clkgen: a CLK_DIV divider that emits a one-cycle edge strobe and a leading/trailing flag while enabled. It clears on disable and on reset.
- Kept in the top level: shift register, bit counter, FSM, select decode.

## Test plan
- Defaults, mode 0, MSB first, tx=8'h55, slave at index 1 returns 8'hAA. Required:
  - ss_n=3'b101 throughout;
  - mosi bits 0,1,0,1,… sampled on sclk rising edges;
  - rx_data=8'hAA at done;
  - done at t+37.
- Sweep all four modes with tx=8'hC3 and a loopback (miso=mosi). Required:
  - rx_data=8'hC3 each time;
  - sclk idles at CPOL before and after each transfer;
  - exactly 16 sclk edges per transfer.
- lsb_first=1, tx=8'h01: mosi is 1 on the first bit only. A slave sending 1,0,0,0,0,0,0,0 yields rx_data=8'h01.
- slaveselct=3 with NUM_SS=3: err pulses once, busy stays 0, ss_n stays 3'b111, rx_data is unchanged.
- Drop reset low at cycle t+10 of a transfer: ss_n=3'b111, sclk=0, busy=0 immediately, and no done. A fresh start then completes normally.
- DATA_W=16, NUM_SS=4, CLK_DIV=3, start re-asserted in the done cycle. Required:
  - the second transfer begins with no idle cycle;
  - each transfer takes 1+3·34=103 cycles;
  - loopback data matches per word.
